instr_decode: RTL
=================

Name: instr_decode

Overview:
RV32I decode stage that sits directly upstream of register_select. It accepts 32-bit instructions through a valid/ready handshake and registers the decoded fields: RS1, RS2, RD, immediate, opcode, funct3, funct7 and control flags. Register indices are driven straight to register_select. A 32-entry pending-write scoreboard holds back any decoded instruction whose source registers are still awaiting writeback (RAW hazards).

Parameters:
WIDTH, 32, datapath width for the PC and immediate.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction present
in_ready  output  1  stage can accept the instruction
in_instr  input  32  raw instruction word
in_pc  input  WIDTH  PC of the instruction
out_valid  output  1  decoded instruction valid and hazard-free
out_ready  input  1  downstream accepts this cycle
RS1  output  5  source register 1 index (0 if unused)
RS2  output  5  source register 2 index (0 if unused)
RD  output  5  destination index (0 if no write)
imm  output  WIDTH  sign-extended immediate
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7  output  7  instr[31:25]
out_pc  output  WIDTH  registered in_pc
reg_write  output  1  instruction writes RD
illegal  output  1  unsupported opcode
wb_valid  input  1  writeback completing
wb_rd  input  5  register being written back
flush  input  1  discard the held instruction

Behaviour:
- Reset (rst high at a clk edge): held=0, pending=0. All outputs go to 0, including out_valid and imm.
- Single holding register with a flag `held`.
- Ready: in_ready = !flush && (!held || (out_valid && out_ready)).
- Accept: in_valid && in_ready at edge N. Fields decode and register at edge N; out_valid can assert at the earliest in cycle N+1 (latency 1).
- Release: out_valid = held && !hazard. Fire = out_valid && out_ready. After a fire with no new accept, held clears.
- Hazard: (use_rs1 && RS1!=0 && pending[RS1]) || (use_rs2 && RS2!=0 && pending[RS2]).
  - Evaluated from the registered scoreboard only; there is no same-cycle bypass from wb_valid.
  - A hazard clears one cycle after the matching writeback.
- Scoreboard set: on fire with reg_write and RD!=0, set pending[RD].
- Scoreboard clear: wb_valid clears pending[wb_rd].
  - If set and clear hit the same index in the same cycle, set wins.
  - pending[0] is never set.
- Opcode decode:
  - LUI 0110111: U-type imm, writes RD.
  - AUIPC 0010111: U-type imm, writes RD.
  - JAL 1101111: J-type imm, writes RD.
  - JALR 1100111: I-type imm, uses RS1, writes RD.
  - BRANCH 1100011: B-type imm, uses RS1 and RS2, no RD write.
  - LOAD 0000011: I-type imm, uses RS1, writes RD.
  - STORE 0100011: S-type imm, uses RS1 and RS2, no RD write.
  - OP-IMM 0010011: I-type imm, uses RS1, writes RD.
  - OP 0110011: imm=0, uses RS1 and RS2, writes RD.
- Immediates: standard RV32I bit placement, sign-extended from instr[31] to WIDTH. B and J immediates have bit0=0.
- Any other opcode:
  - illegal=1, reg_write=0, RS1=RS2=RD=0, imm=0.
  - No hazard check and no scoreboard update; the instruction still passes through the handshake.
- Unused source fields output 0; RD outputs 0 when reg_write=0.
- Output fields are stable while out_valid=0 and held=1 (stall), and while out_valid && !out_ready.
- Flush:
  - held clears at the next edge and in_ready=0 that cycle, so no accept.
  - pending is untouched, because in-flight writes still complete.
  - rst has priority over flush.
- Back-to-back: when fire and accept happen in the same cycle, the new instruction replaces the old one with no bubble.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, RS1=0, RD=1, imm=5, reg_write=1; fire sets pending[1].
- Then 0x00108133 (add x2,x1,x1) -> held with out_valid=0. Pulse wb_valid with wb_rd=1 -> out_valid=1 one cycle later, RS1=RS2=1, RD=2.
- 0xFE20AE23 (sw x2,-4(x1)) -> imm=0xFFFFFFFC, RS1=1, RS2=2, RD=0, reg_write=0, no scoreboard set.
- 0x00000000 -> illegal=1, all indices 0, out_valid=1 next cycle despite any pending bits.
- out_ready=0 for 3 cycles with a valid instruction held -> in_ready=0, outputs stable. Set out_ready=1 with a new in_valid -> fire and accept in the same cycle, then the new instruction appears next cycle.
- Flush while a hazard-stalled instruction is held -> out_valid stays 0 and held clears while pending bits are kept. Asserting rst mid-stall -> all outputs 0 and pending=0.

Source files
------------

// File: rtl/instr_decode.sv
// RV32I decode stage: one-entry holding register with a valid/ready handshake
// and a 32-entry pending-write scoreboard that stalls on RAW hazards.
module instr_decode #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       RS1,
    output logic [4:0]       RS2,
    output logic [4:0]       RD,
    output logic [WIDTH-1:0] imm,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [WIDTH-1:0] out_pc,
    output logic             reg_write,
    output logic             illegal,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic             held_q, held_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic [REG_W-1:0] rs1_q, rs2_q, rd_q;
    logic [WIDTH-1:0] imm_q, pc_q;
    logic [6:0]       opcode_q, funct7_q;
    logic [2:0]       funct3_q;
    logic             reg_write_q, illegal_q;

    logic             hazard, fire, accept;
    logic             dec_use_rs1, dec_use_rs2, dec_rw, dec_ill;
    logic [31:0]      dec_imm32;
    logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd;

    // Raw immediate formats, all sign-extended from bit 31.
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_rw      = 1'b0;
        dec_ill     = 1'b0;
        dec_imm32   = '0;
        unique case (in_instr[6:0])
            OP_LUI, OP_AUIPC: begin dec_imm32 = imm_u; dec_rw = 1'b1; end
            OP_JAL:           begin dec_imm32 = imm_j; dec_rw = 1'b1; end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                dec_imm32 = imm_i; dec_use_rs1 = 1'b1; dec_rw = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm32 = imm_b; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
            end
            OP_STORE: begin
                dec_imm32 = imm_s; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
            end
            OP_OP: begin
                dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; dec_rw = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign dec_rs1 = dec_use_rs1 ? in_instr[19:15] : '0;
    assign dec_rs2 = dec_use_rs2 ? in_instr[24:20] : '0;
    assign dec_rd  = dec_rw      ? in_instr[11:7]  : '0;

    // Unused sources are zeroed at decode, so a zero index never stalls.
    assign hazard    = ((rs1_q != '0) && pending_q[rs1_q]) ||
                       ((rs2_q != '0) && pending_q[rs2_q]);
    assign out_valid = held_q && !hazard;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !flush && (!held_q || fire);
    assign accept    = in_valid && in_ready;

    always_comb begin
        held_d = held_q;
        if (flush)       held_d = 1'b0;
        else if (accept) held_d = 1'b1;
        else if (fire)   held_d = 1'b0;
    end

    // Set after clear so a same-cycle set on the same index wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) pending_d[wb_rd] = 1'b0;
        if (fire && reg_write_q && (rd_q != '0)) pending_d[rd_q] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q      <= 1'b0;
            pending_q   <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            held_q    <= held_d;
            pending_q <= pending_d;
            if (accept) begin
                rs1_q       <= dec_rs1;
                rs2_q       <= dec_rs2;
                rd_q        <= dec_rd;
                imm_q       <= WIDTH'($signed(dec_imm32));
                pc_q        <= in_pc;
                opcode_q    <= in_instr[6:0];
                funct3_q    <= in_instr[14:12];
                funct7_q    <= in_instr[31:25];
                reg_write_q <= dec_rw;
                illegal_q   <= dec_ill;
            end
        end
    end

    assign RS1       = rs1_q;
    assign RS2       = rs2_q;
    assign RD        = rd_q;
    assign imm       = imm_q;
    assign out_pc    = pc_q;
    assign opcode    = opcode_q;
    assign funct3    = funct3_q;
    assign funct7    = funct7_q;
    assign reg_write = reg_write_q;
    assign illegal   = illegal_q;

endmodule
